// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   rx_state_e   - receiver FSM states
//   MIN_DIV      - smallest usable clk cycles per bit
//   DATA_BITS    - payload bits per frame (LSB first)
//   STOP_BITS    - stop bits per frame
//   frame_cycles - clk cycles one whole frame occupies for a given divisor
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  localparam int MIN_DIV   = 4;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Divisors below MIN_DIV are run at MIN_DIV, so the frame length follows suit.
  function automatic int frame_cycles(input int div);
    int d;
    d = (div < MIN_DIV) ? MIN_DIV : div;
    return d * (1 + DATA_BITS + STOP_BITS);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word-fall-through synchronous FIFO.
//   clk, rst_n      - clock, async active-low reset (FIFO empties)
//   push, push_data - write request and data
//   pop             - read request; ignored while empty
//   pop_data        - head entry, forced to 0 while empty
//   count           - occupancy 0..DEPTH
//   full, empty     - occupancy flags
// A push while full is still accepted when a pop happens in the same cycle:
// the write lands in the slot being vacated.
module uart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH by themselves.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a small receive FIFO.
//   clk, rst_n - system clock, async active-low reset
//   ser_rx     - serial line, idles high, asynchronous to clk
//   clk_div    - clk cycles per bit (min MIN_DIV), sampled when leaving IDLE
//   rx_data    - head-of-FIFO byte, valid while rx_valid
//   rx_valid   - FIFO non-empty
//   rx_ready   - consumer accept; pop on rx_valid & rx_ready
//   rx_count   - FIFO occupancy
//   frame_err  - one-cycle pulse when a stop bit is sampled low
//   overrun    - sticky: a byte was dropped because the FIFO was full
//   clr_err    - synchronous clear of overrun (a same-cycle new overrun wins)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ser_rx,
  input  logic [DIV_W-1:0]            clk_div,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        frame_err,
  output logic                        overrun,
  input  logic                        clr_err
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 rx_s_q, rx_s_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 push_q, push_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic                 rx_fall;
  logic [DIV_W-1:0]     div_in, half_m1, div_m1;
  logic                 fifo_full, fifo_empty, drop;

  assign rx_fall = rx_prev_q & ~rx_s_q;
  assign div_in  = (clk_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : clk_div;
  assign half_m1 = (div_q >> 1) - DIV_W'(1);
  assign div_m1  = div_q - DIV_W'(1);

  // A full FIFO always has a head entry, so rx_ready alone means a pop frees a slot.
  assign drop = push_q & fifo_full & ~rx_ready;

  // Next-state logic. START waits half a bit so every later sample lands mid-bit;
  // push and frame_err are registered, which adds the final cycle of latency.
  always_comb begin
    sync1_d     = ser_rx;
    rx_s_d      = sync1_q;
    rx_prev_d   = rx_s_q;
    state_d     = state_q;
    cnt_d       = cnt_q + DIV_W'(1);
    div_d       = div_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = (overrun_q & ~clr_err) | drop;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_fall) begin
          div_d   = div_in;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == half_m1) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            bit_idx_d = '0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == div_m1) begin
          cnt_d     = '0;
          shreg_d   = {rx_s_q, shreg_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + BIT_W'(1);
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (cnt_q == div_m1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push_d  = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) must go high before a new start is accepted.
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      cnt_q       <= '0;
      div_q       <= DIV_W'(MIN_DIV);
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      rx_prev_q   <= rx_prev_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_BITS)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_q),
    .push_data(shreg_q),
    .pop      (rx_ready),
    .pop_data (rx_data),
    .count    (rx_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign rx_valid  = ~fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo.
// A table of single-byte receptions (data, divisor, expected byte and start-edge
// to rx_valid latency), hand-written sequences for glitch, framing, overflow,
// full-with-pop and mid-frame reset, then randomized traffic against a queue model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ser_rx;
  logic [31:0] clk_div;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [3:0]  rx_count;
  logic        frame_err;
  logic        overrun;
  logic        clr_err;

  int checks   = 0;
  int errors   = 0;
  int fe_count = 0;
  logic [7:0] model_q[$];
  bit send_done;

  typedef struct {
    logic [7:0] data;
    int         div;
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];

  uart_rx_fifo #(
    .FIFO_DEPTH(8),
    .DIV_W     (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ser_rx   (ser_rx),
    .clk_div  (clk_div),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_count (rx_count),
    .frame_err(frame_err),
    .overrun  (overrun),
    .clr_err  (clr_err)
  );

  always #5 clk = ~clk;

  // Each high cycle of frame_err is counted, so a stretched pulse counts twice.
  always @(negedge clk) begin
    if (frame_err) fe_count++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one 8N1 frame starting at the next falling clk edge; stop_low holds
  // the stop position low for that many bit times before the line returns high.
  task automatic applyStimulus(input logic [7:0] data, input int div, input int stop_low);
    int d;
    d = (div < MIN_DIV) ? MIN_DIV : div;
    clk_div = div;
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (d) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = data[i];
      repeat (d) @(negedge clk);
    end
    if (stop_low > 0) begin
      ser_rx = 1'b0;
      repeat (stop_low * d) @(negedge clk);
    end
    ser_rx = 1'b1;
    repeat (d + 2) @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, rx_valid, 0);
    checkOutput({tag, "_count"}, rx_count, 0);
    checkOutput({tag, "_data"}, rx_data, 0);
    checkOutput({tag, "_frame_err"}, frame_err, 0);
    checkOutput({tag, "_overrun"}, overrun, 0);
  endtask

  // Sends one byte with rx_ready high and measures clk edges from the start
  // edge until rx_valid is first seen.
  task automatic receiveCheck(input string name, input logic [7:0] data, input int div,
                              input logic [7:0] exp_data, input int exp_lat);
    int lat;
    int budget;
    bit got;
    logic [7:0] seen;
    lat    = 0;
    got    = 1'b0;
    seen   = 8'h00;
    budget = 20 * ((div < MIN_DIV) ? MIN_DIV : div) + 50;
    rx_ready = 1'b1;
    fork
      applyStimulus(data, div, 0);
      begin
        @(negedge clk);
        while (!got && lat < budget) begin
          @(posedge clk);
          #1;
          lat++;
          if (rx_valid) begin
            got  = 1'b1;
            seen = rx_data;
          end
        end
      end
    join
    checkOutput({name, "_latency"}, lat, exp_lat);
    checkOutput({name, "_data"}, seen, exp_data);
  endtask

  task automatic popSequence(input string name, input logic [7:0] exp[8]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx_ready = 1'b1;
      checkOutput(name, rx_data, exp[i]);
    end
    @(negedge clk);
    rx_ready = 1'b0;
    checkOutput({name, "_empty_count"}, rx_count, 0);
  endtask

  initial begin
    logic [7:0] exp8[8];
    int base_fe;
    int budget;

    rst_n   = 1'b1;
    ser_rx  = 1'b1;
    clk_div = 32'd16;
    rx_ready = 1'b0;
    clr_err = 1'b0;
    #1 rst_n = 1'b0;

    vecs[0] = '{8'h55, 16, 8'h55, 156};
    vecs[1] = '{8'hA3, 16, 8'hA3, 156};
    vecs[2] = '{8'h00, 4,  8'h00, 42};
    vecs[3] = '{8'hFF, 2,  8'hFF, 42};
    vecs[4] = '{8'h81, 7,  8'h81, 70};
    vecs[5] = '{8'h6B, 5,  8'h6B, 51};

    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Table-driven single-byte receptions.
    for (int i = 0; i < 6; i++) begin
      receiveCheck($sformatf("vec%0d", i), vecs[i].data, vecs[i].div,
                   vecs[i].exp_data, vecs[i].exp_lat);
      repeat (5) @(negedge clk);
    end
    checkOutput("table_no_frame_err", fe_count, 0);
    checkOutput("table_count", rx_count, 0);

    // Glitch shorter than half a bit is rejected silently.
    rx_ready = 1'b0;
    clk_div  = 32'd16;
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (5) @(negedge clk);
    ser_rx = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("glitch_count", rx_count, 0);
    checkOutput("glitch_valid", rx_valid, 0);
    checkOutput("glitch_frame_err", fe_count, 0);

    // Framing error: stop bit held low for two bit times.
    applyStimulus(8'h3C, 16, 2);
    repeat (5) @(negedge clk);
    checkOutput("framing_pulses", fe_count, 1);
    checkOutput("framing_count", rx_count, 0);
    receiveCheck("after_framing", 8'h7E, 16, 8'h7E, 156);
    checkOutput("after_framing_pulses", fe_count, 1);

    // Overflow: nine bytes into an eight-entry FIFO.
    rx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) applyStimulus(8'(i), 4, 0);
    repeat (10) @(negedge clk);
    checkOutput("overflow_count", rx_count, 8);
    checkOutput("overflow_flag", overrun, 1);
    for (int i = 0; i < 8; i++) exp8[i] = 8'(i + 1);
    popSequence("overflow_pop", exp8);
    checkOutput("overrun_sticky", overrun, 1);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checkOutput("overrun_cleared", overrun, 0);

    // Full FIFO with a pop in the very cycle the ninth byte is pushed.
    for (int i = 0; i < 8; i++) applyStimulus(8'h10 + 8'(i), 4, 0);
    repeat (5) @(negedge clk);
    checkOutput("full_count", rx_count, 8);
    fork
      applyStimulus(8'hEE, 4, 0);
      begin
        @(negedge clk);
        repeat (41) @(posedge clk);
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    checkOutput("full_pop_overrun", overrun, 0);
    checkOutput("full_pop_count", rx_count, 8);
    for (int i = 0; i < 7; i++) exp8[i] = 8'h11 + 8'(i);
    exp8[7] = 8'hEE;
    popSequence("full_pop_seq", exp8);

    // Reset in the middle of a frame, with a byte already queued.
    applyStimulus(8'h5A, 4, 0);
    repeat (3) @(negedge clk);
    checkOutput("prereset_count", rx_count, 1);
    fork
      applyStimulus(8'h99, 16, 0);
      begin
        @(negedge clk);
        repeat (88) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midframe_rst");
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkResetOutputs("post_rst");
    receiveCheck("post_rst_rx", 8'h42, 4, 8'h42, 42);
    repeat (3) @(negedge clk);
    checkOutput("post_rst_final_count", rx_count, 0);

    // Randomized traffic against an in-order queue model; rx_ready toggles
    // randomly but drains fast enough that nothing is dropped.
    send_done = 1'b0;
    budget    = 12 * frame_cycles(12) + 4000;
    fork
      begin
        logic [7:0] rb;
        int rd;
        for (int i = 0; i < 12; i++) begin
          rb = 8'($urandom);
          rd = $urandom_range(4, 12);
          model_q.push_back(rb);
          applyStimulus(rb, rd, 0);
          repeat ($urandom_range(1, 20)) @(negedge clk);
        end
        send_done = 1'b1;
      end
      begin
        int cyc;
        cyc = 0;
        while (!(send_done && model_q.size() == 0) && cyc < budget) begin
          @(negedge clk);
          rx_ready = 1'($urandom_range(0, 1));
          if (rx_valid && rx_ready) begin
            if (model_q.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL rand_extra: got 0x%0h, expected no byte", rx_data);
            end else begin
              checkOutput("rand_byte", rx_data, model_q.pop_front());
            end
          end
          cyc++;
        end
        if (cyc >= budget) begin
          checks++;
          errors++;
          $display("[TB] FAIL rand_timeout: got %0d bytes pending, expected 0", model_q.size());
        end
      end
    join
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rand_final_count", rx_count, 0);
    checkOutput("rand_overrun", overrun, 0);
    checkOutput("rand_frame_err", fe_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
